// File: rtl/keccak_byte_feeder_if.sv
// Byte-stream to keccak word-input bundle.
// Signals:
//   byte_in[7:0], byte_valid, byte_last, byte_ready  - byte stream (source -> feeder)
//   empty_msg                                        - zero-length message request
//   word[63:0], word_valid, word_last,
//   word_byte_num[2:0], word_ack                     - keccak input port (feeder -> core)
//   done                                             - final word consumed
// Modports:
//   master - the feeder side (drives byte_ready, the word bus and done)
//   slave  - the environment side (byte source plus keccak core)
interface keccak_byte_feeder_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        empty_msg;
  logic [63:0] word;
  logic        word_valid;
  logic        word_last;
  logic [2:0]  word_byte_num;
  logic        word_ack;
  logic        done;

  modport master (
    input  byte_in, byte_valid, byte_last, empty_msg, word_ack,
    output byte_ready, word, word_valid, word_last, word_byte_num, done
  );

  modport slave (
    output byte_in, byte_valid, byte_last, empty_msg, word_ack,
    input  byte_ready, word, word_valid, word_last, word_byte_num, done
  );
endinterface

// File: rtl/keccak_byte_feeder.sv
// keccak_byte_feeder
// Packs a byte stream little-endian into 64-bit words and drives the keccak
// core's word-input handshake, terminating the message with a correctly
// marked final word (partial word with byte count, or an all-zero word with
// byte_num=0 when the message length is a multiple of 8). One message per
// reset; after the final word is consumed, done stays high until reset.
// Ports:
//   clk    - clock, all logic on posedge
//   reset  - synchronous active-high reset, clears all state
//   bus    - keccak_byte_feeder_if.master (byte stream in, keccak word bus out)
module keccak_byte_feeder (
  input  logic                 clk,
  input  logic                 reset,
  keccak_byte_feeder_if.master bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TAIL  = 2'd1,
    LASTW = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] acc_reg, acc_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        ov_reg, ov_next;
  logic [63:0] word_reg, word_next;
  logic        last_reg, last_next;
  logic [2:0]  bnum_reg, bnum_next;
  logic        taken_reg, taken_next;   // at least one byte taken since reset

  logic [63:0] merged;                  // accumulator with the incoming byte in lane cnt
  logic        acked;
  logic        empty_take;
  logic        byte_ready_int;
  logic        take;

  // Lanes above cnt are always zero in the accumulator (it is cleared on
  // every word load), so a final partial word needs no extra masking.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign merged[gi*8 +: 8] = (cnt_reg == 3'(gi)) ? bus.byte_in : acc_reg[gi*8 +: 8];
  end

  assign acked      = ov_reg && bus.word_ack;
  assign empty_take = (state_reg == FILL) && (cnt_reg == 3'd0) && !ov_reg &&
                      !taken_reg && bus.empty_msg;
  // Combinational from word_ack: a byte completing a word may be taken in
  // the same cycle the previous word leaves the output register.
  assign byte_ready_int = (state_reg == FILL) && (!ov_reg || bus.word_ack) && !empty_take;
  assign take           = bus.byte_valid && byte_ready_int;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ov_next    = ov_reg;
    word_next  = word_reg;
    last_next  = last_reg;
    bnum_next  = bnum_reg;
    taken_next = taken_reg;

    // Output word leaves at the acked edge; any load below overrides this.
    if (acked) begin
      ov_next = 1'b0;
    end

    case (state_reg)
      FILL: begin
        if (empty_take) begin
          ov_next    = 1'b1;
          word_next  = 64'd0;
          last_next  = 1'b1;
          bnum_next  = 3'd0;
          state_next = LASTW;
        end else if (take) begin
          taken_next = 1'b1;
          if (!bus.byte_last && cnt_reg != 3'd7) begin
            acc_next = merged;
            cnt_next = cnt_reg + 3'd1;
          end else begin
            ov_next   = 1'b1;
            word_next = merged;
            acc_next  = 64'd0;
            cnt_next  = 3'd0;
            if (!bus.byte_last) begin
              last_next = 1'b0;
              bnum_next = 3'd0;
            end else if (cnt_reg != 3'd7) begin
              last_next  = 1'b1;
              bnum_next  = cnt_reg + 3'd1;
              state_next = LASTW;
            end else begin
              // Full final word: keccak still needs an empty terminator.
              last_next  = 1'b0;
              bnum_next  = 3'd0;
              state_next = TAIL;
            end
          end
        end
      end
      TAIL: begin
        if (acked) begin
          ov_next    = 1'b1;
          word_next  = 64'd0;
          last_next  = 1'b1;
          bnum_next  = 3'd0;
          state_next = LASTW;
        end
      end
      LASTW: begin
        if (acked) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FILL;
      acc_reg   <= 64'd0;
      cnt_reg   <= 3'd0;
      ov_reg    <= 1'b0;
      word_reg  <= 64'd0;
      last_reg  <= 1'b0;
      bnum_reg  <= 3'd0;
      taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ov_reg    <= ov_next;
      word_reg  <= word_next;
      last_reg  <= last_next;
      bnum_reg  <= bnum_next;
      taken_reg <= taken_next;
    end
  end

  assign bus.byte_ready    = byte_ready_int;
  assign bus.word          = word_reg;
  assign bus.word_valid    = ov_reg;
  assign bus.word_last     = last_reg;
  assign bus.word_byte_num = bnum_reg;
  assign bus.done          = (state_reg == DONE);

endmodule

// File: tb/tb_keccak_byte_feeder.sv
module tb_keccak_byte_feeder;

  typedef struct {
    logic [63:0] w;
    logic        l;
    logic [2:0]  bn;
  } exp_t;

  logic clk;
  logic reset;
  keccak_byte_feeder_if bus ();

  keccak_byte_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run  = 0;
  int fail_count = 0;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         gap_pct       = 0;
  bit         rand_ack      = 0;
  bit         mark_last     = 1;
  bit         noise_empty   = 0;
  bit         stall_pending = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Reference model: a message of L bytes becomes floor(L/8) full words,
  // then either a partial word with L%8 bytes or an all-zero terminator.
  task automatic push_expected(input bit is_empty);
    exp_t e;
    int   n;
    n = msg_q.size();
    if (is_empty) begin
      e.w = 64'd0; e.l = 1'b1; e.bn = 3'd0;
      exp_q.push_back(e);
      return;
    end
    for (int base = 0; base < n; base += 8) begin
      e.w = 64'd0;
      for (int k = 0; k < 8 && base + k < n; k++) begin
        e.w = e.w | (64'(msg_q[base+k]) << (8 * k));
      end
      if (n - base >= 8) begin
        e.l = 1'b0; e.bn = 3'd0;
      end else begin
        e.l = 1'b1; e.bn = 3'(n - base);
      end
      exp_q.push_back(e);
    end
    if (n % 8 == 0) begin
      e.w = 64'd0; e.l = 1'b1; e.bn = 3'd0;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: chooses word_ack each cycle and checks every consumed word.
  initial begin : monitor
    logic [63:0] held_word;
    logic        held_last;
    logic [2:0]  held_bn;
    bit          held_valid;
    bit          ack;
    int          hold_cnt;
    exp_t        e;
    held_valid = 0;
    hold_cnt   = 0;
    bus.word_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_valid   = 0;
        hold_cnt     = 0;
        bus.word_ack = 1'b0;
        continue;
      end
      if (stall_pending && bus.word_valid) begin
        stall_pending = 0;
        hold_cnt      = 10;
      end
      if (hold_cnt > 0) begin
        ack = 1'b0;
        hold_cnt--;
        bus.word_ack = ack;
        #1;
        check("stall_byte_ready", 64'(bus.byte_ready), 64'd0);
      end else begin
        ack = rand_ack ? ($urandom_range(0, 2) != 0) : 1'b1;
        bus.word_ack = ack;
      end
      if (bus.word_valid) begin
        if (held_valid) begin
          check("held_word", bus.word, held_word);
          check("held_last", 64'(bus.word_last), 64'(held_last));
          check("held_byte_num", 64'(bus.word_byte_num), 64'(held_bn));
        end
        if (ack) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            fail_count++;
            $display("FAIL unexpected_word: got %h last %0d, required no word", bus.word, bus.word_last);
          end else begin
            e = exp_q.pop_front();
            check("word", bus.word, e.w);
            check("word_last", 64'(bus.word_last), 64'(e.l));
            check("word_byte_num", 64'(bus.word_byte_num), 64'(e.bn));
            $display("[TB] word %h last %0d byte_num %0d", bus.word, bus.word_last, bus.word_byte_num);
          end
          held_valid = 0;
        end else begin
          held_valid = 1;
          held_word  = bus.word;
          held_last  = bus.word_last;
          held_bn    = bus.word_byte_num;
        end
      end else begin
        held_valid = 0;
      end
    end
  end

  task automatic idle_inputs();
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'd0;
    bus.byte_last  = 1'b0;
    bus.empty_msg  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_msg();
    int idx   = 0;
    int guard = 0;
    while (idx < msg_q.size()) begin
      @(negedge clk);
      bus.byte_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.byte_in    = bus.byte_valid ? msg_q[idx] : 8'($urandom);
      bus.byte_last  = bus.byte_valid && mark_last && (idx == msg_q.size() - 1);
      bus.empty_msg  = (idx > 0) && noise_empty && ($urandom_range(0, 3) == 0);
      #1;
      if (bus.byte_valid && bus.byte_ready) idx++;
      guard++;
      if (guard > 3000) begin
        tests_run++;
        fail_count++;
        $display("FAIL byte_timeout: got %0d bytes taken, required %0d", idx, msg_q.size());
        break;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!bus.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("done", 64'(bus.done), 64'd1);
    check("words_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic post_done_checks();
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h5A;
    #1;
    check("done_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("done_word_valid", 64'(bus.word_valid), 64'd0);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic run_msg();
    if (mark_last) push_expected(0);
    drive_msg();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_word_valid", 64'(bus.word_valid), 64'd0);
    check("rst_word_last", 64'(bus.word_last), 64'd0);
    check("rst_byte_num", 64'(bus.word_byte_num), 64'd0);
    check("rst_word", bus.word, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd1);
    reset = 1'b0;

    // Five-byte message, partial final word.
    msg_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_msg();
    wait_done();
    post_done_checks();

    // Exactly one full word: needs an empty terminator.
    do_reset();
    msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_msg();
    wait_done();

    // Zero-length message.
    do_reset();
    msg_q.delete();
    push_expected(1);
    @(negedge clk);
    bus.empty_msg = 1'b1;
    @(negedge clk);
    bus.empty_msg = 1'b0;
    wait_done();
    post_done_checks();

    // empty_msg wins over a simultaneous byte.
    do_reset();
    msg_q.delete();
    push_expected(1);
    @(negedge clk);
    bus.empty_msg  = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h55;
    #1;
    check("empty_vs_byte_ready", 64'(bus.byte_ready), 64'd0);
    @(negedge clk);
    idle_inputs();
    wait_done();

    // Sixteen bytes back-to-back with a 10-cycle ack stall on the first word.
    do_reset();
    msg_q.delete();
    for (int i = 0; i < 16; i++) msg_q.push_back(8'(i));
    stall_pending = 1;
    run_msg();
    wait_done();

    // Reset in the middle of a message discards the partial word.
    do_reset();
    msg_q = '{8'h11, 8'h22, 8'h33};
    mark_last = 0;
    run_msg();
    mark_last = 1;
    do_reset();
    check("midrst_word_valid", 64'(bus.word_valid), 64'd0);
    check("midrst_byte_ready", 64'(bus.byte_ready), 64'd1);
    msg_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    run_msg();
    wait_done();

    // Random messages with random gaps, random ack and ignored empty_msg noise.
    rand_ack    = 1;
    gap_pct     = 30;
    noise_empty = 1;
    for (int m = 0; m < 15; m++) begin
      do_reset();
      msg_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) msg_q.push_back(8'($urandom));
      run_msg();
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
